// File: rtl/product_accumulator_128b_pkg.sv
// Shared definitions for the product accumulator and its neighbours.
// Holds the FSM state encoding and the default datapath widths so the
// multiplier wrapper, the accumulator and the bench all agree.
package product_accumulator_128b_pkg;

   // FSM encoding; 2'd3 is unused and treated as IDLE
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ACC  = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   localparam int DATA_W_DEF = 128;  // product width from the multiplier
   localparam int ACC_W_DEF  = 136;  // DATA_W + 8 guard bits
   localparam int CNT_W_DEF  = 16;   // term counter width

endpackage

// File: rtl/product_accumulator_128b.sv
// Purpose: sums valid/last framed bursts of unsigned products into a wide accumulator.
// Latency: accepted term visible on oAcc/oCnt one cycle later; oValid one cycle after the last term.
// Backpressure: input never stalls; terms arriving while a result is held unconsumed are dropped (oDrop).
//
// Ports:
//   iClk, iRst (sync, active-high), iEn (freeze when low), iClr (sync clear)
//   iData/iValid/iLast : product stream from the multiplier (no backpressure)
//   iReady             : consumer accepts the held result
//   oAcc/oCnt/oOvf     : result, term count (saturating), sticky burst overflow
//   oValid             : result held; oDrop sticky drop flag; oBusy state != IDLE
module product_accumulator_128b
   import product_accumulator_128b_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              iClk,
   input  logic              iRst,
   input  logic              iEn,
   input  logic              iClr,
   input  logic [DATA_W-1:0] iData,
   input  logic              iValid,
   input  logic              iLast,
   input  logic              iReady,
   output logic [ACC_W-1:0]  oAcc,
   output logic [CNT_W-1:0]  oCnt,
   output logic              oValid,
   output logic              oOvf,
   output logic              oDrop,
   output logic              oBusy
);

   logic [1:0]       state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             drop_q, drop_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;

   logic [ACC_W-1:0] data_ext;
   logic [ACC_W:0]   acc_sum;   // MSB is the carry out of the accumulator
   logic [CNT_W-1:0] cnt_inc;

   always_comb begin
      data_ext = '0;
      data_ext[DATA_W-1:0] = iData;
   end

   assign acc_sum = {1'b0, acc_q} + {1'b0, data_ext};
   assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      drop_d  = drop_q;

      if (iClr) begin
         state_d = ST_IDLE;
         acc_d   = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
         drop_d  = 1'b0;
      end else if (iEn) begin
         case (state_q)
            ST_ACC: begin
               if (iValid) begin
                  acc_d = acc_sum[ACC_W-1:0];
                  ovf_d = ovf_q | acc_sum[ACC_W];
                  cnt_d = cnt_inc;
                  if (iLast) state_d = ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (iReady) begin
                  // Transfer completes; a same-cycle term opens the next burst
                  // so back-to-back bursts need no bubble.
                  if (iValid) begin
                     acc_d   = data_ext;
                     cnt_d   = CNT_W'(1);
                     ovf_d   = 1'b0;
                     state_d = iLast ? ST_HOLD : ST_ACC;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else if (iValid) begin
                  drop_d = 1'b1;
               end
            end
            default: begin
               // IDLE, and the unused encoding which falls back to IDLE
               if (iValid) begin
                  acc_d   = data_ext;
                  cnt_d   = CNT_W'(1);
                  ovf_d   = 1'b0;
                  state_d = iLast ? ST_HOLD : ST_ACC;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         endcase
      end
   end

   // Status outputs registered from next-state so they come straight off flops
   always_comb begin
      valid_d = (state_d == ST_HOLD);
      busy_d  = (state_d == ST_ACC) || (state_d == ST_HOLD);
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         drop_q  <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         drop_q  <= drop_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   assign oAcc   = acc_q;
   assign oCnt   = cnt_q;
   assign oOvf   = ovf_q;
   assign oDrop  = drop_q;
   assign oValid = valid_q;
   assign oBusy  = busy_q;

endmodule

// File: tb/tb_product_accumulator_128b.sv
// Directed bench for product_accumulator_128b with a result scoreboard.
// Stimulus pushes expected results; a negedge monitor pops on each handshake.
// Other checks (reset, freeze, drop, clear) are made inline by the stimulus.
module tb_product_accumulator_128b;
   import product_accumulator_128b_pkg::*;

   localparam int DW = DATA_W_DEF;
   localparam int AW = ACC_W_DEF;
   localparam int CW = CNT_W_DEF;

   typedef struct packed {
      logic [AW-1:0] acc;
      logic [CW-1:0] cnt;
      logic          ovf;
   } exp_t;

   logic          iClk = 1'b0;
   logic          iRst, iEn, iClr, iValid, iLast, iReady;
   logic [DW-1:0] iData;
   logic [AW-1:0] oAcc;
   logic [CW-1:0] oCnt;
   logic          oValid, oOvf, oDrop, oBusy;

   int   tests_run    = 0;
   int   tests_failed = 0;
   exp_t sb[$];

   always #5 iClk = ~iClk;

   product_accumulator_128b dut (
      .iClk(iClk), .iRst(iRst), .iEn(iEn), .iClr(iClr),
      .iData(iData), .iValid(iValid), .iLast(iLast), .iReady(iReady),
      .oAcc(oAcc), .oCnt(oCnt), .oValid(oValid), .oOvf(oOvf),
      .oDrop(oDrop), .oBusy(oBusy)
   );

   task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Apply inputs, let one rising edge capture them, settle 1 time unit.
   task automatic step(input logic v, input logic [DW-1:0] d, input logic l, input logic r);
      iValid = v; iData = d; iLast = l; iReady = r;
      @(posedge iClk);
      #1;
   endtask

   task automatic push(input logic [AW-1:0] a, input logic [CW-1:0] c, input logic o);
      exp_t e;
      e.acc = a; e.cnt = c; e.ovf = o;
      sb.push_back(e);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_acc"},   oAcc, '0);
      chk({tag, "_cnt"},   AW'(oCnt), '0);
      chk({tag, "_valid"}, AW'(oValid), '0);
      chk({tag, "_ovf"},   AW'(oOvf), '0);
      chk({tag, "_drop"},  AW'(oDrop), '0);
      chk({tag, "_busy"},  AW'(oBusy), '0);
   endtask

   // Monitor: a handshake completes at the coming edge when these are high.
   always @(negedge iClk) begin
      if (oValid && iReady && iEn && !iRst && !iClr) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_result", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("res_acc", oAcc, e.acc);
            chk("res_cnt", AW'(oCnt), AW'(e.cnt));
            chk("res_ovf", AW'(oOvf), AW'(e.ovf));
         end
      end
   end

   initial begin
      logic [AW-1:0] ovf_exp;
      logic [DW-1:0] all_ones;

      iRst = 1'b1; iEn = 1'b1; iClr = 1'b0;
      iValid = 1'b0; iLast = 1'b0; iReady = 1'b0; iData = '0;
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk_zero("reset");
      iRst = 1'b0;

      // 3-term burst 5+7+9 = 21
      push(AW'(21), CW'(3), 1'b0);
      step(1, 5, 0, 1);
      step(1, 7, 0, 1);
      chk("burst_partial_acc", oAcc, AW'(12));
      chk("burst_partial_cnt", AW'(oCnt), AW'(2));
      chk("burst_partial_valid", AW'(oValid), 0);
      chk("burst_busy", AW'(oBusy), 1);
      step(1, 9, 1, 1);
      chk("burst_valid_rise", AW'(oValid), 1);
      step(0, 0, 0, 1);
      chk("burst_valid_fall", AW'(oValid), 0);
      chk("burst_acc_retained", oAcc, AW'(21));

      // 300 terms of 2^128-1: 300 mod 256 = 44, so result = 44*2^128 - 300
      all_ones = '1;
      ovf_exp = AW'(44) << 128;
      ovf_exp = ovf_exp - AW'(300);
      push(ovf_exp, CW'(300), 1'b1);
      for (int i = 0; i < 300; i++) step(1, all_ones, (i == 299), 1);
      chk("ovf_valid", AW'(oValid), 1);
      chk("ovf_flag", AW'(oOvf), 1);
      step(0, 0, 0, 1);
      chk("ovf_idle_busy", AW'(oBusy), 0);

      // Backpressure: held 0x10, term 0x99 in cycle 2 dropped
      step(1, 'h10, 1, 0);
      push(AW'('h10), CW'(1), 1'b0);
      step(0, 0, 0, 0);
      chk("bp_c1_valid", AW'(oValid), 1);
      chk("bp_c1_drop", AW'(oDrop), 0);
      chk("bp_ovf_cleared", AW'(oOvf), 0);
      step(1, 'h99, 0, 0);
      chk("bp_c2_acc", oAcc, AW'('h10));
      chk("bp_c2_drop", AW'(oDrop), 1);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("bp_c4_acc", oAcc, AW'('h10));
      chk("bp_c4_valid", AW'(oValid), 1);
      chk("bp_c4_cnt", AW'(oCnt), AW'(1));
      step(0, 0, 0, 1);
      chk("bp_done_valid", AW'(oValid), 0);
      chk("bp_drop_sticky", AW'(oDrop), 1);

      // Back-to-back: consume 0x20 while starting a single-term burst of 3
      step(1, 'h20, 1, 0);
      push(AW'('h20), CW'(1), 1'b0);
      push(AW'(3), CW'(1), 1'b0);
      step(1, 3, 1, 1);
      chk("b2b_valid", AW'(oValid), 1);
      chk("b2b_acc", oAcc, AW'(3));
      chk("b2b_cnt", AW'(oCnt), AW'(1));
      step(0, 0, 0, 1);
      chk("b2b_done_valid", AW'(oValid), 0);

      // Enable low mid-burst freezes state; terms are ignored
      step(1, 1, 0, 1);
      iEn = 1'b0;
      step(1, 100, 0, 1);
      step(1, 100, 1, 1);
      chk("en_acc_frozen", oAcc, AW'(1));
      chk("en_cnt_frozen", AW'(oCnt), AW'(1));
      chk("en_valid_frozen", AW'(oValid), 0);
      iEn = 1'b1;
      push(AW'(3), CW'(2), 1'b0);
      step(1, 2, 1, 1);
      chk("en_resume_valid", AW'(oValid), 1);
      step(0, 0, 0, 1);

      // Clear mid-burst at 0x55
      step(1, 'h55, 0, 1);
      chk("clr_pre_acc", oAcc, AW'('h55));
      iClr = 1'b1;
      step(1, 7, 0, 1);
      iClr = 1'b0;
      chk_zero("clr");
      step(1, 4, 0, 1);
      chk("clr_new_acc", oAcc, AW'(4));
      chk("clr_new_cnt", AW'(oCnt), AW'(1));

      // Reset mid-burst at 0x55 (4 + 0x51)
      step(1, 'h51, 0, 1);
      chk("rst_pre_acc", oAcc, AW'('h55));
      iRst = 1'b1;
      step(1, 7, 0, 1);
      iRst = 1'b0;
      chk_zero("rst");
      push(AW'(4), CW'(1), 1'b0);
      step(1, 4, 1, 1);
      chk("rst_new_acc", oAcc, AW'(4));
      chk("rst_new_valid", AW'(oValid), 1);
      step(0, 0, 0, 1);

      for (int i = 0; i < 20 && sb.size() != 0; i++) step(0, 0, 0, 1);
      chk("sb_drained", AW'(sb.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
